f_le_arbiter: RTL and testbench

- Round-robin arbiter sharing one combinational f_less_or_equal comparator among N_REQ requesters, such as several float-sort FSMs.
- Each granted request gets a registered result one cycle later.
- A requester may lock the comparator for back-to-back compare sequences, e.g. a 3-compare sort. A lock is bounded by a timeout so no other requester starves.

---
 rtl/f_le_arbiter.sv | 166 ++++++++++++++++
 tb/tb_f_le_arbiter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/f_le_arbiter.sv
// Round-robin arbiter that shares one combinational f_less_or_equal comparator
// among N_REQ requesters, with optional time-bounded ownership locking.
module f_le_arbiter #(
    parameter int FLEN     = 64,
    parameter int N_REQ    = 4,
    parameter int LOCK_MAX = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ-1:0]               lock,
    input  logic [N_REQ-1:0][FLEN-1:0]     req_a,
    input  logic [N_REQ-1:0][FLEN-1:0]     req_b,
    output logic [N_REQ-1:0]               gnt,
    output logic [N_REQ-1:0]               rsp_valid,
    output logic                           rsp_res,
    output logic                           rsp_err,
    output logic                           lock_timeout,
    output logic                           owner_locked,
    output logic [FLEN-1:0]                f_le_a,
    output logic [FLEN-1:0]                f_le_b,
    input  logic                           f_le_res,
    input  logic                           f_le_err
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic [0:0] {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [IW-1:0]     rr_ptr_r;
    logic [IW-1:0]     rr_ptr_s;
    logic [IW-1:0]     owner_r;
    logic [IW-1:0]     owner_s;
    logic [CW-1:0]     lock_cnt_r;
    logic [CW-1:0]     lock_cnt_s;
    logic              timeout_s;
    logic [N_REQ-1:0]  gnt_s;
    logic              arb_found_s;
    logic [IW-1:0]     arb_idx_s;
    logic [FLEN-1:0]   f_le_a_s;
    logic [FLEN-1:0]   f_le_b_s;

    // Successor index modulo N_REQ, safe for non-power-of-two requester counts.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        logic [IW-1:0] nxt;
        if (int'(idx) >= N_REQ - 1) begin
            nxt = {IW{1'b0}};
        end else begin
            nxt = idx + {{(IW-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    // Rotating priority scan: first asserted req at rr_ptr, rr_ptr+1, ...
    always_comb begin
        int cand;
        logic hit;
        arb_found_s = 1'b0;
        arb_idx_s   = {IW{1'b0}};
        cand        = 0;
        hit         = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            cand        = int'(rr_ptr_r) + k;
            cand        = (cand >= N_REQ) ? (cand - N_REQ) : cand;
            hit         = !arb_found_s && req[cand];
            arb_idx_s   = hit ? IW'(cand) : arb_idx_s;
            arb_found_s = arb_found_s | hit;
        end
    end

    // Next-state, grant and lock-counter logic.
    always_comb begin
        state_s    = state_r;
        rr_ptr_s   = rr_ptr_r;
        owner_s    = owner_r;
        lock_cnt_s = lock_cnt_r;
        timeout_s  = 1'b0;
        gnt_s      = {N_REQ{1'b0}};
        case (state_r)
            ST_ARB: begin
                if (arb_found_s) begin
                    gnt_s[arb_idx_s] = 1'b1;
                    if (lock[arb_idx_s]) begin
                        owner_s    = arb_idx_s;
                        lock_cnt_s = {{(CW-1){1'b0}}, 1'b1};
                        state_s    = ST_LOCKED;
                    end else begin
                        rr_ptr_s = next_idx(arb_idx_s);
                    end
                end else begin
                    gnt_s = {N_REQ{1'b0}};
                end
            end
            ST_LOCKED: begin
                // The owner is served in its release cycle too, normal or forced.
                gnt_s[owner_r] = req[owner_r];
                if (!lock[owner_r]) begin
                    state_s    = ST_ARB;
                    rr_ptr_s   = next_idx(owner_r);
                    lock_cnt_s = {CW{1'b0}};
                end else if (lock_cnt_r == CW'(LOCK_MAX)) begin
                    state_s    = ST_ARB;
                    rr_ptr_s   = next_idx(owner_r);
                    lock_cnt_s = {CW{1'b0}};
                    timeout_s  = 1'b1;
                end else begin
                    lock_cnt_s = lock_cnt_r + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_s    = ST_ARB;
                lock_cnt_s = {CW{1'b0}};
            end
        endcase
    end

    // Operand mux toward the shared comparator; zero when nothing is granted.
    always_comb begin
        f_le_a_s = {FLEN{1'b0}};
        f_le_b_s = {FLEN{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            f_le_a_s = f_le_a_s | (gnt_s[i] ? req_a[i] : {FLEN{1'b0}});
            f_le_b_s = f_le_b_s | (gnt_s[i] ? req_b[i] : {FLEN{1'b0}});
        end
    end

    assign gnt          = gnt_s;
    assign f_le_a       = f_le_a_s;
    assign f_le_b       = f_le_b_s;
    assign owner_locked = (state_r == ST_LOCKED);

    // State registers and one-cycle response capture.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_ARB;
            rr_ptr_r     <= {IW{1'b0}};
            owner_r      <= {IW{1'b0}};
            lock_cnt_r   <= {CW{1'b0}};
            rsp_valid    <= {N_REQ{1'b0}};
            rsp_res      <= 1'b0;
            rsp_err      <= 1'b0;
            lock_timeout <= 1'b0;
        end else begin
            state_r      <= state_s;
            rr_ptr_r     <= rr_ptr_s;
            owner_r      <= owner_s;
            lock_cnt_r   <= lock_cnt_s;
            rsp_valid    <= gnt_s;
            lock_timeout <= timeout_s;
            if (|gnt_s) begin
                rsp_res <= f_le_res;
                rsp_err <= f_le_err;
            end else begin
                rsp_res <= rsp_res;
                rsp_err <= rsp_err;
            end
        end
    end

endmodule

// File: tb/tb_f_le_arbiter.sv
// Table-driven bench for f_le_arbiter with a response scoreboard and a
// behavioural float comparator standing in for f_less_or_equal.
module tb_f_le_arbiter;

    localparam int FLEN = 64;
    localparam int NR   = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NR-1:0]           req;
    logic [NR-1:0]           lock;
    logic [NR-1:0][FLEN-1:0] req_a;
    logic [NR-1:0][FLEN-1:0] req_b;
    logic [NR-1:0]           gnt;
    logic [NR-1:0]           rsp_valid;
    logic                    rsp_res;
    logic                    rsp_err;
    logic                    lock_timeout;
    logic                    owner_locked;
    logic [FLEN-1:0]         f_le_a;
    logic [FLEN-1:0]         f_le_b;
    logic                    f_le_res;
    logic                    f_le_err;

    f_le_arbiter #(.FLEN(FLEN), .N_REQ(NR), .LOCK_MAX(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .req_a(req_a), .req_b(req_b), .gnt(gnt), .rsp_valid(rsp_valid),
        .rsp_res(rsp_res), .rsp_err(rsp_err), .lock_timeout(lock_timeout),
        .owner_locked(owner_locked), .f_le_a(f_le_a), .f_le_b(f_le_b),
        .f_le_res(f_le_res), .f_le_err(f_le_err)
    );

    always #5 clk = ~clk;

    // Returns {err, res} for a <= b on IEEE doubles; NaN/Inf flags an error.
    function automatic logic [1:0] fle(input logic [63:0] a, input logic [63:0] b);
        logic e;
        logic r;
        e = (a[62:52] == 11'h7FF) || (b[62:52] == 11'h7FF);
        if (e) r = 1'b0;
        else if (a[63] != b[63]) r = a[63] || ((a[62:0] == 63'd0) && (b[62:0] == 63'd0));
        else if (a[63] == 1'b0) r = (a[62:0] <= b[62:0]);
        else r = (a[62:0] >= b[62:0]);
        return {e, r};
    endfunction

    always_comb {f_le_err, f_le_res} = fle(f_le_a, f_le_b);

    typedef struct {
        logic          rst_n;
        logic [NR-1:0] req;
        logic [NR-1:0] lock;
        logic [NR-1:0] gnt;
        logic          locked;
        logic          tmo;
    } vec_t;

    typedef struct {
        logic [NR-1:0] valid;
        logic          res;
        logic          err;
    } rsp_t;

    rsp_t sb[$];
    int   n_vec = 0;
    int   n_chk = 0;
    int   n_err = 0;
    logic last_res = 1'b0;
    logic last_err = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (vector %0d): actual %h required %h", name, n_vec, act, exp);
        end
    endtask

    // One cycle: check last cycle's response and current state outputs, then drive and check grant.
    task automatic apply(input vec_t v);
        rsp_t          e;
        int            idx;
        logic [1:0]    m;
        @(negedge clk);
        n_vec++;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("rsp_valid", 64'(rsp_valid), 64'(e.valid));
            chk("rsp_res", 64'(rsp_res), 64'(e.res));
            chk("rsp_err", 64'(rsp_err), 64'(e.err));
        end else begin
            chk("scoreboard_underflow", 64'(sb.size()), 64'd1);
        end
        chk("owner_locked", 64'(owner_locked), 64'(v.locked));
        chk("lock_timeout", 64'(lock_timeout), 64'(v.tmo));
        rst_n = v.rst_n;
        req   = v.req;
        lock  = v.lock;
        #1;
        chk("gnt", 64'(gnt), 64'(v.gnt));
        idx = -1;
        for (int i = 0; i < NR; i++) if (v.gnt[i]) idx = i;
        if (idx >= 0) begin
            chk("f_le_a", f_le_a, req_a[idx]);
            chk("f_le_b", f_le_b, req_b[idx]);
            m        = fle(req_a[idx], req_b[idx]);
            last_err = m[1];
            last_res = m[0];
        end else begin
            chk("f_le_a_idle", f_le_a, 64'd0);
        end
        if (!v.rst_n) begin
            last_res = 1'b0;
            last_err = 1'b0;
            e = '{valid: 4'b0000, res: 1'b0, err: 1'b0};
        end else begin
            e = '{valid: v.gnt, res: last_res, err: last_err};
        end
        sb.push_back(e);
    endtask

    vec_t tbl[29];

    initial begin
        //           rst   req      lock     gnt      lkd   tmo
        tbl[0]  = '{1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0}; // single compare
        tbl[1]  = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0}; // reset rr_ptr
        tbl[3]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0}; // round robin
        tbl[4]  = '{1'b1, 4'b1111, 4'b0000, 4'b0010, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 4'b1111, 4'b0000, 4'b0100, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 4'b1111, 4'b0000, 4'b1000, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[8]  = '{1'b1, 4'b0111, 4'b0010, 4'b0010, 1'b0, 1'b0}; // lock by req1
        tbl[9]  = '{1'b1, 4'b0111, 4'b0010, 4'b0010, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 4'b0111, 4'b0000, 4'b0010, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 4'b0111, 4'b0000, 4'b0100, 1'b0, 1'b0};
        tbl[12] = '{1'b1, 4'b0111, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 4'b1100, 4'b0100, 4'b0100, 1'b0, 1'b0}; // timeout, LOCK_MAX=4
        tbl[14] = '{1'b1, 4'b1100, 4'b0100, 4'b0100, 1'b1, 1'b0};
        tbl[15] = '{1'b1, 4'b1100, 4'b0100, 4'b0100, 1'b1, 1'b0};
        tbl[16] = '{1'b1, 4'b1100, 4'b0100, 4'b0100, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 4'b1100, 4'b0100, 4'b0100, 1'b1, 1'b0};
        tbl[18] = '{1'b1, 4'b1100, 4'b0100, 4'b1000, 1'b0, 1'b1};
        tbl[19] = '{1'b1, 4'b1100, 4'b0100, 4'b0100, 1'b0, 1'b0};
        tbl[20] = '{1'b1, 4'b0000, 4'b0100, 4'b0000, 1'b1, 1'b0}; // owner idles, keeps lock
        tbl[21] = '{1'b1, 4'b0100, 4'b0000, 4'b0100, 1'b1, 1'b0};
        tbl[22] = '{1'b1, 4'b1000, 4'b1000, 4'b1000, 1'b0, 1'b0}; // reset mid-lock, owner 3
        tbl[23] = '{1'b1, 4'b1000, 4'b1000, 4'b1000, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 4'b0000, 4'b1000, 4'b0000, 1'b1, 1'b0};
        tbl[25] = '{1'b1, 4'b1001, 4'b0000, 4'b0001, 1'b0, 1'b0};
        tbl[26] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};
        tbl[27] = '{1'b1, 4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b0}; // lock of non-granted ignored
        tbl[28] = '{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0};

        req_a[0] = 64'h4000000000000000; req_b[0] = 64'h3FF0000000000000; // 2.0 <= 1.0
        req_a[1] = 64'h3FF0000000000000; req_b[1] = 64'h4000000000000000; // 1.0 <= 2.0
        req_a[2] = 64'hBFF0000000000000; req_b[2] = 64'h3FF0000000000000; // -1.0 <= 1.0
        req_a[3] = 64'h4008000000000000; req_b[3] = 64'h4008000000000000; // 3.0 <= 3.0
        rst_n = 1'b0;
        req   = 4'b0000;
        lock  = 4'b0000;
        repeat (2) @(posedge clk);
        sb.push_back('{valid: 4'b0000, res: 1'b0, err: 1'b0});

        for (int i = 0; i < 29; i++) apply(tbl[i]);

        // Error path: NaN operand on requester 0, then a clean compare on requester 3.
        req_a[0] = 64'h7FF8000000000000;
        apply('{1'b1, 4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0});
        apply('{1'b1, 4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0});
        apply('{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0});
        apply('{1'b1, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
